// File: rtl/fft_input_loader_if.sv
// Stream-in and FFT-core-side signal bundle for fft_input_loader.
// The loader attaches to the slave modport; the upstream source and core model use master.
interface fft_input_loader_if #(
    parameter int D_WIDTH = 64
);
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_Re;
    logic [15:0] in_Im;
    logic        in_last;
    logic        fft_start;
    logic        fft_done;
    logic [15:0] sig_Re [D_WIDTH];
    logic [15:0] sig_Im [D_WIDTH];
    logic        busy;
    logic        frame_err;
    logic [15:0] frames_launched;

    modport master (
        output in_valid, in_Re, in_Im, in_last, fft_done,
        input  in_ready, fft_start, sig_Re, sig_Im, busy, frame_err, frames_launched
    );

    modport slave (
        input  in_valid, in_Re, in_Im, in_last, fft_done,
        output in_ready, fft_start, sig_Re, sig_Im, busy, frame_err, frames_launched
    );
endinterface

// File: rtl/fft_input_loader.sv
// Assembles one FFT frame from a serial complex stream, launches the core and holds the frame until done.
// Optional macro FFT_LOADER_BITREV_EN: store samples at bit-reversed index instead of natural order.
module fft_input_loader #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_input_loader_if.slave    bus
);
    typedef enum logic [1:0] {FILL, LAUNCH, BUSY} state_t;

    state_t                 state_q;
    logic [LOG_2_WIDTH-1:0] wr_cnt_q;
    logic [LOG_2_WIDTH-1:0] wr_addr;
    logic [15:0]            re_q [D_WIDTH];
    logic [15:0]            im_q [D_WIDTH];
    logic                   in_ready_q;
    logic                   fft_start_q;
    logic                   busy_q;
    logic                   frame_err_q;
    logic [15:0]            frames_q;
    logic                   accept;
    logic                   cnt_full;
    logic                   frame_end;

    function automatic logic [LOG_2_WIDTH-1:0] bit_rev(input logic [LOG_2_WIDTH-1:0] v);
        logic [LOG_2_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < LOG_2_WIDTH; b++) begin
            r[b] = v[LOG_2_WIDTH-1-b];
        end
        return r;
    endfunction

`ifdef FFT_LOADER_BITREV_EN
    assign wr_addr = bit_rev(wr_cnt_q);
`else
    assign wr_addr = wr_cnt_q;
`endif

    assign accept    = (state_q == FILL) && bus.in_valid;
    assign cnt_full  = &wr_cnt_q;
    assign frame_end = accept && (bus.in_last || cnt_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            fft_start_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            frames_q    <= '0;
            for (int i = 0; i < D_WIDTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            fft_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        re_q[wr_addr] <= bus.in_Re;
                        im_q[wr_addr] <= bus.in_Im;
                        if (frame_end) begin
                            state_q     <= LAUNCH;
                            wr_cnt_q    <= '0;
                            in_ready_q  <= 1'b0;
                            fft_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            // A full frame without in_last means the source lost framing.
                            frame_err_q <= cnt_full && !bus.in_last;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state_q <= BUSY;
                    if (frames_q != 16'hFFFF) begin
                        frames_q <= frames_q + 16'd1;
                    end
                end
                BUSY: begin
                    if (bus.fft_done) begin
                        state_q    <= FILL;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        // Clearing here gives the next frame its zero padding for free.
                        for (int i = 0; i < D_WIDTH; i++) begin
                            re_q[i] <= '0;
                            im_q[i] <= '0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.fft_start       = fft_start_q;
    assign bus.busy            = busy_q;
    assign bus.frame_err       = frame_err_q;
    assign bus.frames_launched = frames_q;

    generate
        for (genvar gi = 0; gi < D_WIDTH; gi++) begin : g_sig
            assign bus.sig_Re[gi] = re_q[gi];
            assign bus.sig_Im[gi] = im_q[gi];
        end
    endgenerate
endmodule

// File: tb/tb_fft_input_loader.sv
// Directed self-checking bench for fft_input_loader; expected frame contents come from a small index model.
module tb_fft_input_loader;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    logic [15:0] m_re [N];
    logic [15:0] m_im [N];

    fft_input_loader_if #(.D_WIDTH(N)) bus ();

    fft_input_loader #(.D_WIDTH(N), .LOG_2_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.fft_start === 1'b1) start_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog sim_time=%0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int exp_idx(input int k);
`ifdef FFT_LOADER_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < 6; b++) begin
            if (k[b]) r = r | (1 << (5 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
        int n;
        n = 0;
        bus.in_Re    = re;
        bus.in_Im    = im;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int count, input int last_at, input bit gaps, input bit rnd);
        logic [15:0] re;
        logic [15:0] im;
        for (int k = 0; k < count; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) tick();
            end
            re = rnd ? 16'($urandom) : 16'(k);
            im = rnd ? 16'($urandom) : 16'(-k);
            m_re[exp_idx(k)] = re;
            m_im[exp_idx(k)] = im;
            send(re, im, k == last_at);
        end
    endtask

    task automatic done_pulse();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        model_clear();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.fft_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.fft_start !== 1'b0) begin errors++; $display("FAIL reset_fft_start got=%b exp=0", bus.fft_start); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
        checks++; if (bus.frames_launched !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", bus.frames_launched); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== 16'd0 || bus.sig_Im[i] !== 16'd0) begin
                errors++; $display("FAIL reset_entry[%0d] got=%h/%h exp=0/0", i, bus.sig_Re[i], bus.sig_Im[i]);
            end
        end
    endtask

    task automatic test_full_frame();
        int s0;
        s0 = start_cnt;
        send_frame(64, 63, 1'b0, 1'b0);
        checks++; if (start_cnt !== s0) begin errors++; $display("FAIL full_early_start got=%0d exp=%0d", start_cnt, s0); end
        checks++; if (bus.fft_start !== 1'b1) begin errors++; $display("FAIL full_fft_start got=%b exp=1", bus.fft_start); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL full_frame_err got=%b exp=0", bus.frame_err); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
`ifdef FFT_LOADER_BITREV_EN
        checks++; if (bus.sig_Re[32] !== 16'd1) begin errors++; $display("FAIL full_re32 got=%h exp=0001", bus.sig_Re[32]); end
        checks++; if (bus.sig_Re[1] !== 16'd32) begin errors++; $display("FAIL full_re1 got=%h exp=0020", bus.sig_Re[1]); end
        checks++; if (bus.sig_Im[32] !== 16'hFFFF) begin errors++; $display("FAIL full_im32 got=%h exp=ffff", bus.sig_Im[32]); end
`else
        checks++; if (bus.sig_Re[1] !== 16'd1) begin errors++; $display("FAIL full_re1 got=%h exp=0001", bus.sig_Re[1]); end
        checks++; if (bus.sig_Re[32] !== 16'd32) begin errors++; $display("FAIL full_re32 got=%h exp=0020", bus.sig_Re[32]); end
        checks++; if (bus.sig_Im[1] !== 16'hFFFF) begin errors++; $display("FAIL full_im1 got=%h exp=ffff", bus.sig_Im[1]); end
`endif
        checks++; if (bus.sig_Re[63] !== 16'd63) begin errors++; $display("FAIL full_re63 got=%h exp=003f", bus.sig_Re[63]); end
        tick();
        checks++; if (bus.fft_start !== 1'b0) begin errors++; $display("FAIL full_start_width got=%b exp=0", bus.fft_start); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.frames_launched !== 16'd1) begin errors++; $display("FAIL full_frames got=%0d exp=1", bus.frames_launched); end
        checks++; if (start_cnt !== s0 + 1) begin errors++; $display("FAIL full_start_count got=%0d exp=%0d", start_cnt, s0 + 1); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== m_re[i] || bus.sig_Im[i] !== m_im[i]) begin
                errors++; $display("FAIL full_entry[%0d] got=%h/%h exp=%h/%h", i, bus.sig_Re[i], bus.sig_Im[i], m_re[i], m_im[i]);
            end
        end
        done_pulse();
    endtask

    task automatic test_no_last();
        send_frame(64, -1, 1'b0, 1'b0);
        checks++; if (bus.fft_start !== 1'b1) begin errors++; $display("FAIL nolast_fft_start got=%b exp=1", bus.fft_start); end
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL nolast_frame_err got=%b exp=1", bus.frame_err); end
        tick();
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL nolast_err_width got=%b exp=0", bus.frame_err); end
        checks++; if (bus.frames_launched !== 16'd2) begin errors++; $display("FAIL nolast_frames got=%0d exp=2", bus.frames_launched); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== m_re[i] || bus.sig_Im[i] !== m_im[i]) begin
                errors++; $display("FAIL nolast_entry[%0d] got=%h/%h exp=%h/%h", i, bus.sig_Re[i], bus.sig_Im[i], m_re[i], m_im[i]);
            end
        end
        done_pulse();
    endtask

    task automatic test_early_last();
        send_frame(10, 9, 1'b0, 1'b0);
        checks++; if (bus.fft_start !== 1'b1) begin errors++; $display("FAIL early_fft_start got=%b exp=1", bus.fft_start); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL early_frame_err got=%b exp=0", bus.frame_err); end
        checks++; if (bus.sig_Re[63] !== 16'd0) begin errors++; $display("FAIL early_re63 got=%h exp=0000", bus.sig_Re[63]); end
`ifdef FFT_LOADER_BITREV_EN
        checks++; if (bus.sig_Re[36] !== 16'd9) begin errors++; $display("FAIL early_re36 got=%h exp=0009", bus.sig_Re[36]); end
`else
        checks++; if (bus.sig_Re[9] !== 16'd9) begin errors++; $display("FAIL early_re9 got=%h exp=0009", bus.sig_Re[9]); end
`endif
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== m_re[i] || bus.sig_Im[i] !== m_im[i]) begin
                errors++; $display("FAIL early_entry[%0d] got=%h/%h exp=%h/%h", i, bus.sig_Re[i], bus.sig_Im[i], m_re[i], m_im[i]);
            end
        end
        tick();
        done_pulse();
    endtask

    task automatic test_busy_hold();
        int bad;
        do_reset();
        send_frame(64, 63, 1'b0, 1'b1);
        tick();
        bad = 0;
        bus.in_valid = 1'b1;
        bus.in_Re    = 16'hDEAD;
        bus.in_Im    = 16'hBEEF;
        for (int c = 0; c < 20; c++) begin
            if (bus.in_ready !== 1'b0) bad++;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_in_ready high_cycles=%0d exp=0", bad); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== m_re[i] || bus.sig_Im[i] !== m_im[i]) begin
                errors++; $display("FAIL hold_entry[%0d] got=%h/%h exp=%h/%h", i, bus.sig_Re[i], bus.sig_Im[i], m_re[i], m_im[i]);
            end
        end
        done_pulse();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b exp=0", bus.busy); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== 16'd0 || bus.sig_Im[i] !== 16'd0) begin
                errors++; $display("FAIL done_clear[%0d] got=%h/%h exp=0/0", i, bus.sig_Re[i], bus.sig_Im[i]);
            end
        end
        send_frame(64, 63, 1'b0, 1'b0);
        tick();
        checks++; if (bus.frames_launched !== 16'd2) begin errors++; $display("FAIL hold_frames got=%0d exp=2", bus.frames_launched); end
        done_pulse();
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        s0 = start_cnt;
        send_frame(30, -1, 1'b0, 1'b1);
        do_reset();
        checks++; if (start_cnt !== s0) begin errors++; $display("FAIL rstmid_start got=%0d exp=%0d", start_cnt, s0); end
        checks++; if (bus.frames_launched !== 16'd0) begin errors++; $display("FAIL rstmid_frames got=%0d exp=0", bus.frames_launched); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== 16'd0 || bus.sig_Im[i] !== 16'd0) begin
                errors++; $display("FAIL rstmid_clear[%0d] got=%h/%h exp=0/0", i, bus.sig_Re[i], bus.sig_Im[i]);
            end
        end
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stray_done ready/busy got=%b/%b exp=1/0", bus.in_ready, bus.busy);
        end
        send_frame(63, -1, 1'b0, 1'b0);
        tick();
        checks++; if (start_cnt !== s0 || bus.fft_start !== 1'b0) begin
            errors++; $display("FAIL rstmid_early_launch starts=%0d exp=%0d", start_cnt, s0);
        end
        m_re[exp_idx(63)] = 16'd63;
        m_im[exp_idx(63)] = 16'(-63);
        send(16'd63, 16'(-63), 1'b1);
        checks++; if (bus.fft_start !== 1'b1) begin errors++; $display("FAIL rstmid_launch got=%b exp=1", bus.fft_start); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sig_Re[i] !== m_re[i] || bus.sig_Im[i] !== m_im[i]) begin
                errors++; $display("FAIL rstmid_entry[%0d] got=%h/%h exp=%h/%h", i, bus.sig_Re[i], bus.sig_Im[i], m_re[i], m_im[i]);
            end
        end
        tick();
        done_pulse();
    endtask

    task automatic test_random_gaps();
        int s0;
        s0 = start_cnt;
        for (int f = 0; f < 3; f++) begin
            send_frame(64, 63, 1'b1, 1'b1);
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (bus.sig_Re[i] !== m_re[i] || bus.sig_Im[i] !== m_im[i]) begin
                    errors++; $display("FAIL rand_f%0d_entry[%0d] got=%h/%h exp=%h/%h", f, i, bus.sig_Re[i], bus.sig_Im[i], m_re[i], m_im[i]);
                end
            end
            repeat ($urandom_range(0, 3)) tick();
            done_pulse();
        end
        checks++; if (start_cnt !== s0 + 3) begin errors++; $display("FAIL rand_start_count got=%0d exp=%0d", start_cnt - s0, 3); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_Re    = '0;
        bus.in_Im    = '0;
        bus.in_last  = 1'b0;
        bus.fft_done = 1'b0;
        model_clear();
        tick();
        test_reset();
        test_full_frame();
        test_no_last();
        test_early_last();
        test_busy_hold();
        test_reset_mid_frame();
        test_random_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
